// File: rtl/ram_rd_controller.sv
// Read-side controller for the ping-pong sample RAMs feeding the FFT: waits for a
// full RAM, streams it out in address order and produces the frame strobes.
module ram_rd_controller #(
   parameter int ADDR_WIDTH = 9,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  ready,
   input  logic                  sel_ram,
   input  logic                  dst_ready,
   output logic                  rd_en_ram_0,
   output logic                  rd_en_ram_1,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  mux_sel,
   output logic                  out_valid,
   output logic                  out_first,
   output logic                  out_last,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  overrun
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
   localparam logic [2:0]            DRAIN_END = 3'(RD_LATENCY - 1);

   state_t                  state_q, state_d;
   logic                    pending_q, pending_d;
   logic                    pend_sel_q, pend_sel_d;
   logic                    cur_sel_q, cur_sel_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [2:0]              drain_cnt_q, drain_cnt_d;
   logic [RD_LATENCY-1:0]   valid_pipe_q, first_pipe_q, last_pipe_q, sel_pipe_q;
   logic                    start;
   logic                    issuing;

   assign start   = (state_q == IDLE) && pending_q && dst_ready;
   assign issuing = (state_q == ISSUE);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cur_sel_d   = cur_sel_q;
      drain_cnt_d = drain_cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = ISSUE;
               cur_sel_d = pend_sel_q;
               addr_d    = '0;
            end
         end
         ISSUE: begin
            addr_d = addr_q + 1'b1;
            if (addr_q == LAST_ADDR) begin
               state_d     = DRAIN;
               drain_cnt_d = '0;
            end
         end
         DRAIN: begin
            if (drain_cnt_q == DRAIN_END) begin
               state_d = DONE;
            end else begin
               drain_cnt_d = drain_cnt_q + 3'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A new ready always wins over consumption so a back-to-back frame is never dropped.
   always_comb begin
      pending_d  = pending_q;
      pend_sel_d = pend_sel_q;
      if (ready) begin
         pending_d  = 1'b1;
         pend_sel_d = sel_ram;
      end else if (start) begin
         pending_d  = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         pending_q   <= 1'b0;
         pend_sel_q  <= 1'b0;
         cur_sel_q   <= 1'b0;
         addr_q      <= '0;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         pend_sel_q  <= pend_sel_d;
         cur_sel_q   <= cur_sel_d;
         addr_q      <= addr_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   // Strobes travel with the read request so they line up with the RAM data.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_pipe_q <= '0;
         first_pipe_q <= '0;
         last_pipe_q  <= '0;
         sel_pipe_q   <= '0;
      end else begin
         valid_pipe_q[0] <= issuing;
         first_pipe_q[0] <= issuing && (addr_q == '0);
         last_pipe_q[0]  <= issuing && (addr_q == LAST_ADDR);
         sel_pipe_q[0]   <= issuing && cur_sel_q;
         for (int i = 1; i < RD_LATENCY; i++) begin
            valid_pipe_q[i] <= valid_pipe_q[i-1];
            first_pipe_q[i] <= first_pipe_q[i-1];
            last_pipe_q[i]  <= last_pipe_q[i-1];
            sel_pipe_q[i]   <= sel_pipe_q[i-1];
         end
      end
   end

   assign rd_en_ram_0 = issuing && !cur_sel_q;
   assign rd_en_ram_1 = issuing && cur_sel_q;
   assign rd_addr     = addr_q;
   assign out_valid   = valid_pipe_q[RD_LATENCY-1];
   assign out_first   = first_pipe_q[RD_LATENCY-1];
   assign out_last    = last_pipe_q[RD_LATENCY-1];
   assign mux_sel     = sel_pipe_q[RD_LATENCY-1];
   assign busy        = (state_q != IDLE);
   assign frame_done  = (state_q == DONE);
   // Lost frame (pending overwritten) or the writer refilling the RAM under read.
   assign overrun     = ready && ((pending_q && !start) || (busy && (sel_ram == cur_sel_q)));

endmodule

// File: tb/tb_ram_rd_controller.sv
// Bench for ram_rd_controller: a hand-written frame table, directed corner sequences
// and a random run compared against a frame-offset reference model.
module tb_ram_rd_controller;

   localparam int AW = 3;
   localparam int D  = 8;
   localparam int L  = 2;

   logic          clock = 1'b0;
   logic          reset_n = 1'b1;
   logic          ready = 1'b0;
   logic          sel_ram = 1'b0;
   logic          dst_ready = 1'b0;
   logic          rd_en_ram_0, rd_en_ram_1;
   logic [AW-1:0] rd_addr;
   logic          mux_sel, out_valid, out_first, out_last, busy, frame_done, overrun;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference model: a frame is just its start cycle; everything derives from the offset.
   bit mReset = 1'b0;
   bit mPending = 1'b0;
   bit mPendSel = 1'b0;
   bit mFrameSel = 1'b0;
   int mStart = -1;

   typedef struct packed {
      logic       rdy;
      logic       sel;
      logic       dst;
      logic       en0;
      logic       en1;
      logic [2:0] addr;
      logic       valid;
      logic       first;
      logic       last;
      logic       done;
      logic       bsy;
      logic       ovr;
   } vec_t;

   vec_t vecs [14];

   ram_rd_controller #(.ADDR_WIDTH(AW), .RD_LATENCY(L)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .ready      (ready),
      .sel_ram    (sel_ram),
      .dst_ready  (dst_ready),
      .rd_en_ram_0(rd_en_ram_0),
      .rd_en_ram_1(rd_en_ram_1),
      .rd_addr    (rd_addr),
      .mux_sel    (mux_sel),
      .out_valid  (out_valid),
      .out_first  (out_first),
      .out_last   (out_last),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic bit modelBusy();
      return !mReset && (mStart >= 0) && ((cyc - mStart) <= D + L);
   endfunction

   function automatic bit modelConsume();
      return !mReset && !modelBusy() && mPending && dst_ready;
   endfunction

   task automatic modelClear();
      mPending  = 1'b0;
      mPendSel  = 1'b0;
      mFrameSel = 1'b0;
      mStart    = -1;
   endtask

   task automatic modelCheck();
      logic eEn0, eEn1, eValid, eFirst, eLast, eDone, eBusy, eOvr;
      int   eAddr;
      int   k;
      eEn0 = 1'b0; eEn1 = 1'b0; eValid = 1'b0; eFirst = 1'b0;
      eLast = 1'b0; eDone = 1'b0; eAddr = 0;
      eBusy = modelBusy();
      if (eBusy) begin
         k      = cyc - mStart;
         eEn0   = (k < D) && !mFrameSel;
         eEn1   = (k < D) && mFrameSel;
         eAddr  = (k < D) ? k : 0;
         eValid = (k >= L) && (k < L + D);
         eFirst = (k == L);
         eLast  = (k == L + D - 1);
         eDone  = (k == D + L);
      end
      eOvr = !mReset && ready && ((mPending && !modelConsume()) || (eBusy && (sel_ram == mFrameSel)));
      checkOutput("rd_en_ram_0", rd_en_ram_0, eEn0);
      checkOutput("rd_en_ram_1", rd_en_ram_1, eEn1);
      checkOutput("rd_addr", rd_addr, eAddr);
      checkOutput("out_valid", out_valid, eValid);
      checkOutput("out_first", out_first, eFirst);
      checkOutput("out_last", out_last, eLast);
      checkOutput("busy", busy, eBusy);
      checkOutput("frame_done", frame_done, eDone);
      checkOutput("overrun", overrun, eOvr);
      if (eValid || mReset) checkOutput("mux_sel", mux_sel, eValid ? mFrameSel : 1'b0);
   endtask

   task automatic modelAdvance();
      bit c;
      if (mReset) return;
      c = modelConsume();
      if (c) begin
         mStart    = cyc + 1;
         mFrameSel = mPendSel;
      end
      if (ready) begin
         mPending = 1'b1;
         mPendSel = sel_ram;
      end else if (c) begin
         mPending = 1'b0;
      end
   endtask

   task automatic applyStimulus(input logic r, input logic s, input logic d);
      ready     = r;
      sel_ram   = s;
      dst_ready = d;
      #2;
   endtask

   task automatic nextCycle();
      modelAdvance();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic runCycle(input logic r, input logic s, input logic d);
      applyStimulus(r, s, d);
      modelCheck();
      nextCycle();
   endtask

   // Asserts reset asynchronously, toggles inputs while held, releases before cycle 0.
   task automatic doReset(input int n);
      reset_n = 1'b0;
      mReset  = 1'b1;
      modelClear();
      #1;
      modelCheck();
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'(i % 2), 1'((i / 2) % 2), 1'(i % 3 == 0));
         modelCheck();
         nextCycle();
      end
      reset_n   = 1'b1;
      mReset    = 1'b0;
      ready     = 1'b0;
      sel_ram   = 1'b0;
      dst_ready = 1'b0;
   endtask

   initial begin
      int ram0Reads;

      vecs[0]  = '{1'b1,1'b0,1'b1, 1'b0,1'b0,3'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0};
      vecs[1]  = '{1'b0,1'b0,1'b1, 1'b0,1'b0,3'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0};
      vecs[2]  = '{1'b0,1'b0,1'b1, 1'b1,1'b0,3'd0, 1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0};
      vecs[3]  = '{1'b0,1'b0,1'b1, 1'b1,1'b0,3'd1, 1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0};
      vecs[4]  = '{1'b0,1'b0,1'b1, 1'b1,1'b0,3'd2, 1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0};
      vecs[5]  = '{1'b0,1'b0,1'b1, 1'b1,1'b0,3'd3, 1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0};
      vecs[6]  = '{1'b0,1'b0,1'b1, 1'b1,1'b0,3'd4, 1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0};
      vecs[7]  = '{1'b0,1'b0,1'b1, 1'b1,1'b0,3'd5, 1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0};
      vecs[8]  = '{1'b0,1'b0,1'b1, 1'b1,1'b0,3'd6, 1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0};
      vecs[9]  = '{1'b0,1'b0,1'b1, 1'b1,1'b0,3'd7, 1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0};
      vecs[10] = '{1'b0,1'b0,1'b1, 1'b0,1'b0,3'd0, 1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0};
      vecs[11] = '{1'b0,1'b0,1'b1, 1'b0,1'b0,3'd0, 1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0};
      vecs[12] = '{1'b0,1'b0,1'b1, 1'b0,1'b0,3'd0, 1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0};
      vecs[13] = '{1'b0,1'b0,1'b1, 1'b0,1'b0,3'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0};

      #2;
      $display("[TB] reset with toggling inputs, then single RAM 0 frame table");
      doReset(6);
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].rdy, vecs[i].sel, vecs[i].dst);
         checkOutput("tbl_en0", rd_en_ram_0, vecs[i].en0);
         checkOutput("tbl_en1", rd_en_ram_1, vecs[i].en1);
         checkOutput("tbl_addr", rd_addr, vecs[i].addr);
         checkOutput("tbl_valid", out_valid, vecs[i].valid);
         checkOutput("tbl_first", out_first, vecs[i].first);
         checkOutput("tbl_last", out_last, vecs[i].last);
         checkOutput("tbl_done", frame_done, vecs[i].done);
         checkOutput("tbl_busy", busy, vecs[i].bsy);
         checkOutput("tbl_overrun", overrun, vecs[i].ovr);
         checkOutput("tbl_mux_sel", mux_sel, 1'b0);
         modelCheck();
         nextCycle();
      end

      $display("[TB] back-to-back frames, second on RAM 1");
      doReset(2);
      for (int i = 0; i < 27; i++) begin
         applyStimulus(1'(i == 0 || i == 5), 1'(i == 5), 1'b1);
         if (i == 14) checkOutput("b2b_en1_start", rd_en_ram_1, 1'b1);
         if (i == 16) checkOutput("b2b_mux_sel", mux_sel, 1'b1);
         if (i == 24) checkOutput("b2b_done", frame_done, 1'b1);
         modelCheck();
         nextCycle();
      end

      $display("[TB] dst_ready held off until cycle 10");
      doReset(2);
      for (int i = 0; i < 24; i++) begin
         applyStimulus(1'(i == 0), 1'b0, 1'(i >= 10));
         if (i == 10) checkOutput("hold_no_en", rd_en_ram_0, 1'b0);
         if (i == 11) checkOutput("hold_en_start", rd_en_ram_0, 1'b1);
         if (i == 11) checkOutput("hold_addr0", rd_addr, 0);
         modelCheck();
         nextCycle();
      end

      $display("[TB] pending overwritten, then RAM refilled under read");
      doReset(2);
      ram0Reads = 0;
      for (int i = 0; i < 30; i++) begin
         applyStimulus(1'(i == 0 || i == 3), 1'(i == 3), 1'(i >= 5));
         if (i == 3) checkOutput("ovr_overwrite", overrun, 1'b1);
         if (rd_en_ram_0) ram0Reads++;
         modelCheck();
         nextCycle();
      end
      checkOutput("ram0_never_read", ram0Reads, 0);
      doReset(2);
      for (int i = 0; i < 30; i++) begin
         applyStimulus(1'(i == 0 || i == 5), 1'b0, 1'b1);
         if (i == 5) checkOutput("ovr_conflict", overrun, 1'b1);
         if (i == 6) checkOutput("ovr_pulse_end", overrun, 1'b0);
         modelCheck();
         nextCycle();
      end

      $display("[TB] reset in the middle of a frame");
      doReset(2);
      runCycle(1'b1, 1'b0, 1'b1);
      for (int i = 1; i < 6; i++) runCycle(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("mid_addr", rd_addr, 4);
      doReset(3);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'(i == 0), 1'b1, 1'b1);
         if (i == 2) checkOutput("restart_en1", rd_en_ram_1, 1'b1);
         if (i == 2) checkOutput("restart_addr0", rd_addr, 0);
         modelCheck();
         nextCycle();
      end

      $display("[TB] random traffic");
      doReset(2);
      for (int i = 0; i < 3000; i++) begin
         runCycle(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
